qcs_dyn_pre_gen_rd: RTL and testbench
=====================================

// Module: qcs_dyn_pre_gen_rd
// PURPOSE
//  Consumer/reader end of the dynamic preamble generator output port.
//  On a start command, fetches NUM samples by issuing nhtp_re. Captures the
//  2-stream I/Q words that return RD_LAT cycles later into a local FIFO.
//  Presents them downstream as a valid/ready stream with a last flag.
//  Credit-based: never requests more than the FIFO can absorb, so backpressure
//  from downstream never drops generator data.
// PARAMETERS
//  DW         16  I/Q sample width, per component
//  RD_LAT     2   cycles from nhtp_re high to the data_* words being valid (>=1)
//  FIFO_DEPTH 8   capture FIFO depth, power of 2, >= RD_LAT+1
//  LEN_W      12  width of the sample-count command
// PORTS
//  clk        in   1      clock
//  reset_n    in   1      async active-low reset
//  start      in   1      1-cycle pulse; latch num_samp, begin fetch (ignored while busy)
//  num_samp   in   LEN_W  samples to fetch for this command
//  busy       out  1      command in progress
//  done       out  1      1-cycle pulse after the final sample is popped downstream
//  ovf_err    out  1      sticky: capture attempted while FIFO full
//  nhtp_re    out  1      read enable to the preamble generator
//  data_i_0   in   DW     stream 0 I, valid RD_LAT cycles after nhtp_re
//  data_q_0   in   DW     stream 0 Q
//  data_i_1   in   DW     stream 1 I
//  data_q_1   in   DW     stream 1 Q
//  out_valid  out  1      downstream sample valid
//  out_ready  in   1      downstream accept
//  out_i_0/out_q_0/out_i_1/out_q_1 out DW  captured sample, held while valid&!ready
//  out_last   out  1      qualifies the num_samp-th sample
// BEHAVIOUR
//  Reset: one clock (clk); async active-low reset_n. All outputs 0.
//   FSM=IDLE, counters and FIFO cleared, latency pipe cleared.
//  FSM: IDLE -start&num_samp!=0-> FETCH; IDLE -start&num_samp==0-> FIN.
//   FETCH -req_cnt==num_samp-> DRAIN; DRAIN -pop of last sample-> FIN; FIN -> IDLE.
//  busy=1 in FETCH/DRAIN/FIN. done=1 for exactly the FIN cycle.
//  Request rule (FETCH): nhtp_re=1 when req_cnt<num_samp and
//   inflight+fifo_cnt < FIFO_DEPTH. Combinational on registered state; one
//   request per cycle max. Back-to-back requests allowed.
//  Latency pipe: RD_LAT-deep shift of nhtp_re. Its tail writes {i0,q0,i1,q1}
//   into the FIFO that same cycle. inflight = popcount of pipe.
//  Write to a full FIFO: data dropped, ovf_err set (cleared only by reset).
//   Unreachable when the credit rule holds.
//  FIFO read: out_* driven from FIFO head (show-ahead). out_valid = !empty.
//   Pop on out_valid&out_ready. Simultaneous push+pop at full or empty is legal:
//   count unchanged, no ovf.
//  Zero-bubble throughput of 1 sample/cycle when out_ready held high.
//  Write/read pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//  out_last: pop counter == num_samp-1 while out_valid.
//  Counters LEN_W bits. num_samp latched at start; the num_samp input is
//   don't-care afterwards. start during busy: ignored, no error.
//  Reset asserted mid-command: outstanding returning data is discarded.
//   Generator side must also be reset.
// STRUCTURE
//  Package qcs_dyn_pre_pkg: FSM state enum (IDLE,FETCH,DRAIN,FIN), default
//   RD_LAT constant.
//  Sub-module qcs_dyn_pre_fifo #(W=4*DW, DEPTH): sync show-ahead FIFO with
//   count, full, empty. Top holds the FSM, credit logic and latency pipe.
// TESTING
//  1) num_samp=4, out_ready=1, RD_LAT=2 -> nhtp_re high 4 cycles;
//     4 samples in order; out_last on 4th; done 1 cycle after.
//  2) num_samp=20, out_ready=0 -> nhtp_re stops after 8 requests
//     (FIFO_DEPTH); release -> 20 samples, no ovf_err.
//  3) num_samp=0 -> no nhtp_re; done pulses on the cycle after start;
//     busy high 1 cycle.
//  4) Random out_ready 50%, num_samp=100, incrementing data
//     -> data order intact, ovf_err=0.
//  5) reset_n low mid-FETCH (after 3 requests) -> all outputs 0.
//     New start num_samp=2 completes cleanly.
//  6) start pulsed while busy with num_samp=7 -> ignored; original count delivered.

Source files
------------

// File: rtl/qcs_dyn_pre_gen_rd_pkg.sv
// Shared types and default parameters for the dynamic preamble reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qcs_dyn_pre_pkg;

  // Command sequencer states of the reader.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int DW_DEF         = 16;
  localparam int RD_LAT_DEF     = 2;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int LEN_W_DEF      = 12;

endpackage

// File: rtl/qcs_dyn_pre_gen_rd_if.sv
// Bundle of command, generator-read and downstream stream signals of the reader.
// Latency: n/a (wires only).
// Backpressure: out_ready is the only downstream stall input.
// Ports: command (start/num_samp/busy/done/ovf_err), generator read
//   (nhtp_re, data_*), downstream stream (out_valid/out_ready/out_*/out_last).
//   slave = reader block, master = command source + generator + sink.
interface qcs_dyn_pre_gen_rd_if #(
  parameter int DW    = qcs_dyn_pre_pkg::DW_DEF,
  parameter int LEN_W = qcs_dyn_pre_pkg::LEN_W_DEF
);
  logic             start;
  logic [LEN_W-1:0] num_samp;
  logic             busy;
  logic             done;
  logic             ovf_err;
  logic             nhtp_re;
  logic [DW-1:0]    data_i_0;
  logic [DW-1:0]    data_q_0;
  logic [DW-1:0]    data_i_1;
  logic [DW-1:0]    data_q_1;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_i_0;
  logic [DW-1:0]    out_q_0;
  logic [DW-1:0]    out_i_1;
  logic [DW-1:0]    out_q_1;
  logic             out_last;

  modport slave (
    input  start, num_samp, data_i_0, data_q_0, data_i_1, data_q_1, out_ready,
    output busy, done, ovf_err, nhtp_re,
    output out_valid, out_i_0, out_q_0, out_i_1, out_q_1, out_last
  );

  modport master (
    output start, num_samp, data_i_0, data_q_0, data_i_1, data_q_1, out_ready,
    input  busy, done, ovf_err, nhtp_re,
    input  out_valid, out_i_0, out_q_0, out_i_1, out_q_1, out_last
  );

endinterface

// File: rtl/qcs_dyn_pre_gen_rd_fifo.sv
// Synchronous show-ahead FIFO with occupancy count, full and empty flags.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
// Ports: clk, rst_n, push_i/push_dat_i, pop_i, head_dat_o, cnt_o, full_o, empty_o.
module qcs_dyn_pre_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign cnt_o      = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (cnt_o == (AW+1)'(DEPTH));
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so push-at-full is accepted then.
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/qcs_dyn_pre_gen_rd.sv
// Reader of the dynamic preamble generator: fetches num_samp I/Q samples and streams them out.
// Latency: first sample valid RD_LAT+2 cycles after start; then 1 sample/cycle.
// Backpressure: requests are credit-limited to free FIFO space, so out_ready low never loses data.
// Ports: clk, reset_n (async active-low), bus (slave side: command, generator read, out stream).
module qcs_dyn_pre_gen_rd
  import qcs_dyn_pre_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  qcs_dyn_pre_gen_rd_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = 4 * DW;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] req_cnt_q, req_cnt_d;
  logic [LEN_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic             ovf_q, ovf_d;
  logic [AW:0]      inflight, fifo_cnt;
  logic [AW+1:0]    credit_used;
  logic             can_req, req, cap, pop, last_pop;
  logic             fifo_full, fifo_empty;
  logic [W-1:0]     head_dat;

  qcs_dyn_pre_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .push_i     (cap),
    .push_dat_i ({bus.data_i_0, bus.data_q_0, bus.data_i_1, bus.data_q_1}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .cnt_o      (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Every outstanding request ends up in the FIFO, so requests in the pipe
  // plus FIFO occupancy is the credit in use.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (AW+1)'(pipe_q[i]);
  end
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign can_req     = (credit_used < (AW+2)'(FIFO_DEPTH));

  // Tail of the latency pipe marks the cycle the generator's data is valid.
  assign cap = pipe_q[RD_LAT-1];
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = req;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign pop      = ~fifo_empty & bus.out_ready;
  assign last_pop = pop & (pop_cnt_q == num_q - LEN_W'(1));
  assign ovf_d    = ovf_q | (cap & fifo_full & ~pop);

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    req_cnt_d = req_cnt_q;
    pop_cnt_d = pop_cnt_q;
    req       = 1'b0;
    if (pop) pop_cnt_d = pop_cnt_q + LEN_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          num_d     = bus.num_samp;
          req_cnt_d = '0;
          pop_cnt_d = '0;
          state_d   = (bus.num_samp == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (req_cnt_q == num_q) begin
          state_d = ST_DRAIN;
        end else if (can_req) begin
          req       = 1'b1;
          req_cnt_d = req_cnt_q + LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (last_pop) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      req_cnt_q <= '0;
      pop_cnt_q <= '0;
      pipe_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      req_cnt_q <= req_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      pipe_q    <= pipe_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.nhtp_re   = req;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FIN);
  assign bus.ovf_err   = ovf_q;
  assign bus.out_valid = ~fifo_empty;
  // Data forced to zero when nothing is valid so stale FIFO contents never leak.
  assign {bus.out_i_0, bus.out_q_0, bus.out_i_1, bus.out_q_1} = fifo_empty ? '0 : head_dat;
  assign bus.out_last  = ~fifo_empty & (pop_cnt_q == num_q - LEN_W'(1));

endmodule

// File: tb/tb_qcs_dyn_pre_gen_rd.sv
module tb_qcs_dyn_pre_gen_rd;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  qcs_dyn_pre_gen_rd_if #(.DW(DW), .LEN_W(LEN_W)) bus ();

  qcs_dyn_pre_gen_rd #(
    .DW(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Generator sample k: four components derived from a running index.
  function automatic logic [63:0] samp(input int k);
    logic [15:0] b;
    b = 16'(k);
    return {b, b + 16'h1000, b + 16'h2000, b + 16'h3000};
  endfunction

  // Reference model state: samples captured but not yet consumed, command
  // progress in terms of requests issued and samples consumed.
  logic [63:0] exp_q[$];
  logic        re_hist[RD_LAT];
  int          gen_k, m_num, m_reqs, m_pops;
  bit          m_busy, m_done;
  int          cnt_re, cnt_pop, cnt_done, cnt_busy;
  logic [63:0] last_dat;

  always @(negedge clk) begin : mon
    bit          vld_e, last_e, re_e, pop_e, cap, done_n, busy_n;
    logic [63:0] dat, out_dat;
    out_dat = {bus.out_i_0, bus.out_q_0, bus.out_i_1, bus.out_q_1};
    if (!reset_n) begin
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ovf", bus.ovf_err, 0);
      check("rst_re", bus.nhtp_re, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_dat", out_dat, 0);
      exp_q.delete();
      for (int i = 0; i < RD_LAT; i++) re_hist[i] = 1'b0;
      gen_k = 0; m_num = 0; m_reqs = 0; m_pops = 0; m_busy = 0; m_done = 0;
      {bus.data_i_0, bus.data_q_0, bus.data_i_1, bus.data_q_1} = 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      vld_e  = (exp_q.size() != 0);
      last_e = vld_e && (m_pops == m_num - 1);
      re_e   = m_busy && !m_done && (m_reqs < m_num) && ((m_reqs - m_pops) < DEPTH);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("ovf", bus.ovf_err, 0);
      check("nhtp_re", bus.nhtp_re, re_e);
      check("out_valid", bus.out_valid, vld_e);
      check("out_last", bus.out_last, last_e);
      if (vld_e) check("out_dat", out_dat, exp_q[0]);

      if (bus.nhtp_re) cnt_re++;
      if (bus.busy) cnt_busy++;
      if (bus.done) cnt_done++;
      if (bus.out_valid && bus.out_ready) begin
        cnt_pop++;
        last_dat = out_dat;
      end

      done_n = 0;
      busy_n = m_busy;
      if (m_done) busy_n = 0;
      if (re_e) m_reqs++;
      pop_e = vld_e && bus.out_ready;
      if (pop_e) begin
        void'(exp_q.pop_front());
        if (m_pops == m_num - 1) done_n = 1;
        m_pops++;
      end
      if (!m_busy && bus.start) begin
        busy_n = 1;
        m_num  = int'(bus.num_samp);
        m_reqs = 0;
        m_pops = 0;
        done_n = (bus.num_samp == 0);
      end
      m_busy = busy_n;
      m_done = done_n;

      // Generator: answer each read enable exactly RD_LAT cycles later.
      cap = re_hist[RD_LAT-1];
      for (int i = RD_LAT - 1; i > 0; i--) re_hist[i] = re_hist[i-1];
      re_hist[0] = bus.nhtp_re;
      if (cap) begin
        dat = samp(gen_k);
        gen_k++;
        exp_q.push_back(dat);
      end else begin
        dat = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      {bus.data_i_0, bus.data_q_0, bus.data_i_1, bus.data_q_1} = dat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cnt_re = 0; cnt_pop = 0; cnt_done = 0; cnt_busy = 0;
  endtask

  task automatic do_start(input int n);
    tick();
    bus.start    = 1'b1;
    bus.num_samp = LEN_W'(n);
    tick();
    bus.start    = 1'b0;
    bus.num_samp = 12'hABC;
  endtask

  task automatic run_done(input int budget, input bit rnd);
    int c0;
    c0 = cnt_done;
    for (int i = 0; i < budget && cnt_done == c0; i++) begin
      tick();
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.out_ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.num_samp  = '0;
    bus.out_ready = 1'b1;
    clr();
    #2 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("init_busy", bus.busy, 0);
    check("init_valid", bus.out_valid, 0);

    // 1) four samples, sink always ready
    clr();
    do_start(4);
    run_done(50, 0);
    check("t1_re", cnt_re, 4);
    check("t1_pop", cnt_pop, 4);
    check("t1_done", cnt_done, 1);
    check("t1_busy", cnt_busy, 8);
    check("t1_last_dat", last_dat, 64'h0003_1003_2003_3003);

    // 2) sink stalled: requests stop at FIFO depth, then drain
    clr();
    bus.out_ready = 1'b0;
    do_start(20);
    repeat (30) tick();
    check("t2_re_stall", cnt_re, 8);
    check("t2_pop_stall", cnt_pop, 0);
    bus.out_ready = 1'b1;
    run_done(200, 0);
    check("t2_re", cnt_re, 20);
    check("t2_pop", cnt_pop, 20);
    check("t2_done", cnt_done, 1);
    check("t2_last_dat", last_dat, 64'h0017_1017_2017_3017);

    // 3) zero-length command
    clr();
    do_start(0);
    run_done(10, 0);
    check("t3_re", cnt_re, 0);
    check("t3_busy", cnt_busy, 1);
    check("t3_done", cnt_done, 1);
    check("t3_pop", cnt_pop, 0);

    // 4) random sink backpressure, long command
    clr();
    do_start(100);
    run_done(2000, 1);
    check("t4_pop", cnt_pop, 100);
    check("t4_done", cnt_done, 1);
    check("t4_ovf", bus.ovf_err, 0);
    check("t4_last_dat", last_dat, 64'h007B_107B_207B_307B);

    // 5) reset in the middle of fetching, then a clean short command
    clr();
    do_start(20);
    for (int i = 0; i < 20 && cnt_re < 3; i++) tick();
    check("t5_req_before_rst", cnt_re, 3);
    reset_n = 1'b0;
    repeat (2) tick();
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_re", bus.nhtp_re, 0);
    check("t5_rst_valid", bus.out_valid, 0);
    reset_n = 1'b1;
    tick();
    clr();
    do_start(2);
    run_done(50, 0);
    check("t5_pop", cnt_pop, 2);
    check("t5_done", cnt_done, 1);
    check("t5_last_dat", last_dat, 64'h0001_1001_2001_3001);

    // 6) start while busy is ignored
    clr();
    do_start(7);
    tick();
    bus.start    = 1'b1;
    bus.num_samp = LEN_W'(3);
    tick();
    bus.start    = 1'b0;
    run_done(100, 0);
    check("t6_re", cnt_re, 7);
    check("t6_pop", cnt_pop, 7);
    check("t6_done", cnt_done, 1);
    check("t6_last_dat", last_dat, 64'h0008_1008_2008_3008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
